// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I multicycle control unit: opcodes, ALU op
// codes, branch funct3 values, write-back selects, FSM states and decode bundle.
package cpu_pkg;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // Right-shift funct3; the only I-type op where funct7[5] picks the ALU op.
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [2:0] WB_ALU    = 3'd0;
  localparam logic [2:0] WB_BUS    = 3'd1;
  localparam logic [2:0] WB_IMM    = 3'd2;
  localparam logic [2:0] WB_PC_IMM = 3'd3;
  localparam logic [2:0] WB_PC4    = 3'd4;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src;
    logic [2:0] rfwd_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       writes_rd;
    logic       is_mem;
    logic       is_store;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// CPU-side bus handshake toward the APB bridge.
interface cpu_control_fsm_if;
  // Master holds busReq (and busWe for stores) high for every cycle of a
  // transfer; the transfer completes on the first rising edge where busReq
  // and busReady are both high. busReady is ignored while busReq is low.
  logic busReq;
  logic busWe;
  logic busReady;

  modport master (output busReq, output busWe, input busReady);
  modport slave  (input busReq, input busWe, output busReady);
endinterface

// File: rtl/cpu_control_fsm_decoder.sv
// Pure combinational RV32I decode of opcode/funct3/funct7[5] into datapath controls.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_TYPE_R: begin
        dec.alu_control = {funct7_5, funct3};
        dec.rfwd_src    = WB_ALU;
        dec.writes_rd   = 1'b1;
      end
      OP_TYPE_I: begin
        dec.alu_control = {(funct3 == F3_SR) ? funct7_5 : 1'b0, funct3};
        dec.alu_src     = 1'b1;
        dec.rfwd_src    = WB_ALU;
        dec.writes_rd   = 1'b1;
      end
      OP_TYPE_L: begin
        dec.alu_control = ALU_ADD;
        dec.alu_src     = 1'b1;
        dec.rfwd_src    = WB_BUS;
        dec.writes_rd   = 1'b1;
        dec.is_mem      = 1'b1;
      end
      OP_TYPE_S: begin
        dec.alu_control = ALU_ADD;
        dec.alu_src     = 1'b1;
        dec.is_mem      = 1'b1;
        dec.is_store    = 1'b1;
      end
      OP_TYPE_B: begin
        dec.alu_control = {1'b0, funct3};
        dec.branch      = 1'b1;
      end
      OP_TYPE_LU: begin
        dec.alu_control = ALU_ADD;
        dec.rfwd_src    = WB_IMM;
        dec.writes_rd   = 1'b1;
      end
      OP_TYPE_AU: begin
        dec.alu_control = ALU_ADD;
        dec.rfwd_src    = WB_PC_IMM;
        dec.writes_rd   = 1'b1;
      end
      OP_TYPE_J: begin
        dec.alu_control = ALU_ADD;
        dec.rfwd_src    = WB_PC4;
        dec.jal         = 1'b1;
        dec.writes_rd   = 1'b1;
      end
      OP_TYPE_JL: begin
        dec.alu_control = ALU_ADD;
        dec.alu_src     = 1'b1;
        dec.rfwd_src    = WB_PC4;
        dec.jal         = 1'b1;
        dec.jalr        = 1'b1;
        dec.writes_rd   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/COMMIT sequencing,
// registered strobes and a bounded-wait bus master.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               instrCode,
  cpu_control_fsm_if.master         bus,
  output logic                      PCEn,
  output logic                      regFileWe,
  output logic [3:0]                aluControl,
  output logic                      aluSrcMuxSel,
  output logic [2:0]                RFWDSrcMuxSel,
  output logic                      branch,
  output logic                      jal,
  output logic                      jalr,
  output logic                      illegalInstr,
  output logic                      busError,
  output state_t                    state_dbg
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  decode_t dec;
  state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pc_en_q, pc_en_d;
  logic rf_we_q, rf_we_d;
  logic bus_req_q, bus_req_d;
  logic bus_we_q, bus_we_d;
  logic illegal_q, illegal_d;
  logic bus_err_q, bus_err_d;
  logic timeout_hit;
  logic in_fetch;
  logic unused_instr_bits;

  instr_decoder u_decoder (
    .opcode   (instrCode[6:0]),
    .funct3   (instrCode[14:12]),
    .funct7_5 (instrCode[30]),
    .dec      (dec)
  );

  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_q == CW'(BUS_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXECUTE;
      EXECUTE: begin
        if (dec.is_mem) begin
          state_d = MEM;
          cnt_d   = '0;
        end else begin
          state_d = COMMIT;
        end
      end
      MEM: begin
        // A ready in the final allowed cycle still completes normally.
        if (bus.busReady) begin
          state_d = COMMIT;
        end else if (timeout_hit) begin
          state_d   = COMMIT;
          bus_err_d = 1'b1;
        end else if (BUS_TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMMIT:  state_d = FETCH;
      default: state_d = FETCH;
    endcase

    bus_req_d = (state_d == MEM);
    bus_we_d  = (state_d == MEM) && dec.is_store;
    pc_en_d   = (state_d == COMMIT);
    illegal_d = (state_d == COMMIT) && dec.illegal;
    rf_we_d   = (state_d == COMMIT) && dec.writes_rd && !dec.illegal && !bus_err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      pc_en_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      bus_req_q <= 1'b0;
      bus_we_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_en_q   <= pc_en_d;
      rf_we_q   <= rf_we_d;
      bus_req_q <= bus_req_d;
      bus_we_q  <= bus_we_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Decoded controls follow the held instruction but read as zero in FETCH.
  assign in_fetch      = (state_q == FETCH);
  assign aluControl    = in_fetch ? 4'b0000 : dec.alu_control;
  assign aluSrcMuxSel  = in_fetch ? 1'b0 : dec.alu_src;
  assign RFWDSrcMuxSel = in_fetch ? 3'd0 : dec.rfwd_src;
  assign branch        = in_fetch ? 1'b0 : dec.branch;
  assign jal           = in_fetch ? 1'b0 : dec.jal;
  assign jalr          = in_fetch ? 1'b0 : dec.jalr;

  assign PCEn         = pc_en_q;
  assign regFileWe    = rf_we_q;
  assign illegalInstr = illegal_q;
  assign busError     = bus_err_q;
  assign bus.busReq   = bus_req_q;
  assign bus.busWe    = bus_we_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multicycle control unit for the RV32I core datapath. It decodes the held instruction word and steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and COMMIT. It drives every datapath control input (PC enable, register-file write, ALU op, mux selects, branch/jump flags) and acts as the CPU-side bus master toward the APB bridge, using a request/ready handshake with a bounded wait.

## Interface
- `BUS_TIMEOUT`, default 16: maximum MEM cycles waiting for `busReady`. 0 disables the timeout.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instrCode` in 32: instruction word from instruction memory, addressed by the current PC.
- `busReady` in 1: bus transfer complete. Sampled only in MEM.
- `PCEn` out 1: PC register load strobe.
- `regFileWe` out 1: register-file write strobe.
- `aluControl` out 4: ALU operation. Branch compare uses bits [2:0].
- `aluSrcMuxSel` out 1: ALU B operand. 0 = RS2, 1 = immediate.
- `RFWDSrcMuxSel` out 3: write-back source. 0 = ALU, 1 = bus read data, 2 = immediate, 3 = PC+imm, 4 = PC+4.
- `branch` out 1: B-type instruction.
- `jal` out 1: JAL or JALR.
- `jalr` out 1: JALR (PC+imm adder takes RS1).
- `busReq` out 1: bus transfer request.
- `busWe` out 1: bus write (store) when `busReq`=1.
- `illegalInstr` out 1: one-cycle pulse in COMMIT for an unknown opcode.
- `busError` out 1: one-cycle pulse in COMMIT after a bus timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, COMMIT. Encoding is a 3-bit enum.
- State transitions:
  - FETCH→DECODE unconditionally.
  - DECODE→EXECUTE unconditionally.
  - EXECUTE→MEM for opcode L (0000011) or S (0100011). Otherwise EXECUTE→COMMIT.
  - MEM→COMMIT on `busReady`=1, or when the timeout expires.
  - COMMIT→FETCH unconditionally.
- Decoded controls (`aluControl`, `aluSrcMuxSel`, `RFWDSrcMuxSel`, `branch`, `jal`, `jalr`) are combinational on `instrCode`. They are stable from DECODE through COMMIT and forced to 0 in FETCH.
- ALU op codes:
  - R: {funct7[5], funct3}.
  - I: {funct3==101 ? funct7[5] : 0, funct3}.
  - L, S, JALR, AU, LU, J: ADD (0000).
  - B: {0, funct3}.
- Op encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- `aluSrcMuxSel`=1 for I, L, S and JALR.
- `RFWDSrcMuxSel` per opcode: R and I = 0, L = 1, LU = 2, AU = 3, J and JL = 4.
- `busReq`=1 for every MEM cycle. `busWe` = (opcode==S) during MEM, 0 elsewhere.
- `regFileWe`=1 only in COMMIT, for R, I, L, LU, AU, J and JL. It is suppressed when `busError` or `illegalInstr` fires.
- `PCEn`=1 only in COMMIT, for every instruction including illegal or timed-out ones (skipped as a NOP).
- Timeout counter:
  - Cleared on MEM entry; increments each MEM cycle with `busReady`=0.
  - When count reaches `BUS_TIMEOUT`-1 with no ready: leave MEM, drop `busReq`, and pulse `busError` in COMMIT.
  - A `busReady` arriving in that same cycle wins: normal completion, no error.

## Timing
- Reset: state FETCH, timeout counter 0, all outputs 0 on the next edge.
- Reset mid-instruction aborts it immediately. No strobe is asserted on the cycle after the reset edge.
- Latency:
  - Non-memory instructions: 4 cycles.
  - Load or store: 5 cycles with zero wait (`busReady` high in the first MEM cycle), plus 1 per wait cycle.
  - Worst case: 4+`BUS_TIMEOUT` cycles.
- `busReady` is ignored outside MEM. Bus read data is valid on the MEM exit edge, so write-back occurs in COMMIT.
- `busReq` and `busWe` are registered-state decodes and glitch-free within a cycle.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OP_TYPE_R, L, S, I, B, LU, AU, J, JL);
  - ALU op constants;
  - branch funct3 constants;
  - write-back mux select constants;
  - the `state_t` enum.
- One sub-module, `instr_decoder`: pure combinational mapping from opcode/funct3/funct7 to the decoded controls.
- The FSM and the timeout counter stay in `cpu_control_fsm`.

## Test plan
- `ADD x3,x1,x2` (0x002081B3) → `aluControl`=0000 and `RFWDSrcMuxSel`=0 from DECODE; `regFileWe`=`PCEn`=1 only in cycle 4.
- `SW x2,8(x1)` (0x0020A423), `busReady` high after 2 waits → `busReq`/`busWe`=1 for 3 MEM cycles, `regFileWe`=0, `PCEn` in cycle 7.
- `LW x5,0(x1)` (0x0000A283), `busReady` never asserted, `BUS_TIMEOUT`=4 → 4 MEM cycles, then `busError` pulse and `regFileWe`=0 with `PCEn`=1 in COMMIT.
- `BNE x1,x2,+8` (0x00209463) → `branch`=1, `aluControl`[2:0]=001, no write; `JALR x1,0(x5)` (0x000280E7) → `jal`=`jalr`=1, `RFWDSrcMuxSel`=4.
- Opcode 0x7F → `illegalInstr` pulse in COMMIT, `PCEn`=1, `regFileWe`=0.
- `reset` asserted during MEM → `busReq`=0 and state FETCH on the next edge; the following instruction completes normally.
